// File: rtl/hpu_pkg.sv
// Shared types and address-map constants for the hart debug memory slave.
package hpu_pkg;

  typedef enum logic [1:0] {
    RUNNING  = 2'd0,
    HALTED   = 2'd1,
    CMD_GO   = 2'd2,
    RESUMING = 2'd3
  } dm_state_e;

  // Offsets within the 4 KiB debug window (addr[31:12] must be zero).
  localparam logic [11:0] DM_ADDR_HALT   = 12'h100;
  localparam logic [11:0] DM_ADDR_CMD    = 12'h104;
  localparam logic [11:0] DM_ADDR_RESUME = 12'h108;
  localparam logic [11:0] DM_ADDR_EXCEPT = 12'h10C;
  localparam logic [11:0] DM_ADDR_DATA0  = 12'h200;
  localparam logic [11:0] DM_ADDR_FLAGS  = 12'h300;
  localparam logic [11:0] DM_ADDR_CMDW   = 12'h400;

  localparam int DM_PB_DEPTH = 16;

endpackage

// File: rtl/hpu_dm_pbuf.sv
// Program buffer RAM: debugger-side write port, hart-side registered read port.
module hpu_dm_pbuf #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_p1;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // read stage: output holds between reads
  always_ff @(posedge clk) begin
    if (re) rdata_p1 <= mem[raddr];
  end

  assign rdata = rdata_p1;

endmodule

// File: rtl/hpu_dm_mem.sv
// Debug memory slave: program buffer, data0, flags and command word, plus the
// hart/debugger halt-resume-command handshake state machine.
module hpu_dm_mem
  import hpu_pkg::*;
#(
  parameter int PB_DEPTH = DM_PB_DEPTH,
  parameter int CMD_W    = 32,
  localparam int PBW     = $clog2(PB_DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             darb_dm__req_i,
  input  logic             darb_dm__we_i,
  input  logic [31:0]      darb_dm__addr_i,
  input  logic [31:0]      darb_dm__wdata_i,
  output logic [31:0]      dm_darb__rdata_o,
  input  logic             dbg_dm__haltreq_i,
  input  logic             dbg_dm__resumereq_i,
  input  logic             dbg_dm__cmd_valid_i,
  input  logic [CMD_W-1:0] dbg_dm__cmd_data_i,
  output logic             dm_dbg__cmd_ready_o,
  input  logic             dbg_dm__pb_we_i,
  input  logic [PBW:0]     dbg_dm__pb_addr_i,
  input  logic [31:0]      dbg_dm__pb_wdata_i,
  output logic [31:0]      dm_dbg__data0_o,
  output logic             dm_dbg__halted_o,
  output logic             dm_dbg__cmd_busy_o,
  output logic             dm_dbg__cmd_done_o,
  output logic             dm_dbg__cmd_err_o,
  output logic             dm_ctrl__haltreq_o
);

  localparam logic [11:0] PB_END = 12'(4 * PB_DEPTH);

  dm_state_e        state, state_nxt;
  logic             accept, done, except;
  logic             err, done_p1, haltreq_p1;
  logic [CMD_W-1:0] cmd_q;
  logic [31:0]      data0_q;
  logic [31:0]      reg_rdata_p1, rd_mux, pb_rdata;
  logic             pb_sel_p1;

  logic        mapped, rd, wr;
  logic [11:0] offs;
  logic        hit_pb, hit_data0, hit_flags, hit_cmdw;
  logic        wr_halt, wr_cmd, wr_resume, wr_except, wr_data0;
  logic        go, resume, dbg_wr;

  assign mapped    = (darb_dm__addr_i[31:12] == 20'd0);
  assign offs      = darb_dm__addr_i[11:0];
  assign rd        = darb_dm__req_i & ~darb_dm__we_i;
  assign wr        = darb_dm__req_i & darb_dm__we_i & mapped;
  assign hit_pb    = mapped && (offs < PB_END);
  assign hit_data0 = mapped && (offs == DM_ADDR_DATA0);
  assign hit_flags = mapped && (offs == DM_ADDR_FLAGS);
  assign hit_cmdw  = mapped && (offs == DM_ADDR_CMDW);
  assign wr_halt   = wr && (offs == DM_ADDR_HALT);
  assign wr_cmd    = wr && (offs == DM_ADDR_CMD);
  assign wr_resume = wr && (offs == DM_ADDR_RESUME);
  assign wr_except = wr && (offs == DM_ADDR_EXCEPT);
  assign wr_data0  = wr && (offs == DM_ADDR_DATA0);

  // go/resume flags are exactly "in CMD_GO" / "in RESUMING"
  assign go     = (state == CMD_GO);
  assign resume = (state == RESUMING);
  assign dbg_wr = dbg_dm__pb_we_i & (state != CMD_GO);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    except    = 1'b0;
    case (state)
      RUNNING:  if (wr_halt) state_nxt = HALTED;
      HALTED: begin
        if (dbg_dm__cmd_valid_i) begin
          accept    = 1'b1;
          state_nxt = CMD_GO;
        end else if (dbg_dm__resumereq_i) begin
          state_nxt = RESUMING;
        end
      end
      CMD_GO: begin
        if (wr_cmd) begin
          done      = 1'b1;
          state_nxt = HALTED;
        end else if (wr_except) begin
          done      = 1'b1;
          except    = 1'b1;
          state_nxt = HALTED;
        end
      end
      RESUMING: if (wr_resume) state_nxt = RUNNING;
      default:  state_nxt = RUNNING;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= RUNNING;
      err        <= 1'b0;
      done_p1    <= 1'b0;
      haltreq_p1 <= 1'b0;
    end else begin
      state      <= state_nxt;
      done_p1    <= done;
      haltreq_p1 <= dbg_dm__haltreq_i && (state == RUNNING);
      if (except)      err <= 1'b1;
      else if (accept) err <= 1'b0;
    end
  end

  // Hart write to data0 takes priority over a simultaneous debugger write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_q   <= '0;
      data0_q <= '0;
    end else begin
      if (accept) cmd_q <= dbg_dm__cmd_data_i;
      if (wr_data0) data0_q <= darb_dm__wdata_i;
      else if (dbg_wr && dbg_dm__pb_addr_i[PBW]) data0_q <= dbg_dm__pb_wdata_i;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (hit_data0)      rd_mux = data0_q;
    else if (hit_flags) rd_mux = {30'd0, resume, go};
    else if (hit_cmdw)  rd_mux = 32'(cmd_q);
  end

  // read stage: register non-PB data and which source drives rdata
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_rdata_p1 <= '0;
      pb_sel_p1    <= 1'b0;
    end else if (rd) begin
      reg_rdata_p1 <= rd_mux;
      pb_sel_p1    <= hit_pb;
    end
  end

  hpu_dm_pbuf #(.DEPTH(PB_DEPTH)) u_pbuf (
    .clk   (clk_i),
    .we    (dbg_wr & ~dbg_dm__pb_addr_i[PBW]),
    .waddr (dbg_dm__pb_addr_i[PBW-1:0]),
    .wdata (dbg_dm__pb_wdata_i),
    .re    (rd & hit_pb),
    .raddr (darb_dm__addr_i[PBW+1:2]),
    .rdata (pb_rdata)
  );

  assign dm_darb__rdata_o    = pb_sel_p1 ? pb_rdata : reg_rdata_p1;
  assign dm_dbg__cmd_ready_o = (state == HALTED);
  assign dm_dbg__data0_o     = data0_q;
  assign dm_dbg__halted_o    = (state != RUNNING);
  assign dm_dbg__cmd_busy_o  = (state == CMD_GO);
  assign dm_dbg__cmd_done_o  = done_p1;
  assign dm_dbg__cmd_err_o   = err;
  assign dm_ctrl__haltreq_o  = haltreq_p1;

endmodule

// File: tb/tb_hpu_dm_mem.sv
// Directed bench for hpu_dm_mem: read-map vector table plus handshake sequences.
module tb_hpu_dm_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata, rdata;
  logic        haltreq, resumereq, cmd_valid, cmd_ready;
  logic [31:0] cmd_data;
  logic        pb_we;
  logic [4:0]  pb_addr;
  logic [31:0] pb_wdata, data0;
  logic        halted, busy, done, err, haltreq_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  always #5 clk = ~clk;

  hpu_dm_mem #(.PB_DEPTH(16), .CMD_W(32)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .darb_dm__req_i      (req),
    .darb_dm__we_i       (we),
    .darb_dm__addr_i     (addr),
    .darb_dm__wdata_i    (wdata),
    .dm_darb__rdata_o    (rdata),
    .dbg_dm__haltreq_i   (haltreq),
    .dbg_dm__resumereq_i (resumereq),
    .dbg_dm__cmd_valid_i (cmd_valid),
    .dbg_dm__cmd_data_i  (cmd_data),
    .dm_dbg__cmd_ready_o (cmd_ready),
    .dbg_dm__pb_we_i     (pb_we),
    .dbg_dm__pb_addr_i   (pb_addr),
    .dbg_dm__pb_wdata_i  (pb_wdata),
    .dm_dbg__data0_o     (data0),
    .dm_dbg__halted_o    (halted),
    .dm_dbg__cmd_busy_o  (busy),
    .dm_dbg__cmd_done_o  (done),
    .dm_dbg__cmd_err_o   (err),
    .dm_ctrl__haltreq_o  (haltreq_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic hart(input logic w, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; addr = a; wdata = d;
    step();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic dbg_wr(input logic [4:0] a, input logic [31:0] d);
    pb_we = 1'b1; pb_addr = a; pb_wdata = d;
    step();
    pb_we = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 32'h0000_0000, 32'h0,    32'hDEAD_BEEF};
    tbl[1]  = '{1'b1, 32'h0000_0000, 32'h1234, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b0, 32'h0000_0000, 32'h0,    32'hDEAD_BEEF};
    tbl[3]  = '{1'b0, 32'h0000_0004, 32'h0,    32'h1111_1111};
    tbl[4]  = '{1'b0, 32'h0000_0300, 32'h0,    32'h0000_0001};
    tbl[5]  = '{1'b1, 32'h0000_0300, 32'hFF,   32'h0000_0001};
    tbl[6]  = '{1'b0, 32'h0000_0300, 32'h0,    32'h0000_0001};
    tbl[7]  = '{1'b0, 32'h0000_0400, 32'h0,    32'h0022_1000};
    tbl[8]  = '{1'b0, 32'h0000_0200, 32'h0,    32'h0000_0005};
    tbl[9]  = '{1'b0, 32'h0000_0100, 32'h0,    32'h0000_0000};
    tbl[10] = '{1'b0, 32'h0000_1000, 32'h0,    32'h0000_0000};
    tbl[11] = '{1'b0, 32'h0000_0208, 32'h0,    32'h0000_0000};

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    haltreq = 1'b0; resumereq = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
    pb_we = 1'b0; pb_addr = '0; pb_wdata = '0;
    step(); step();
    rst = 1'b0;

    check("rst_halted", 32'(halted), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_data0", data0, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_haltreq", 32'(haltreq_o), 32'd0);
    hart(1'b0, 32'h300, 32'h0); check("rst_flags", rdata, 32'd0);
    hart(1'b0, 32'h104, 32'h0); check("rd_wo_104", rdata, 32'd0);
    hart(1'b0, 32'h1000, 32'h0); check("rd_unmapped", rdata, 32'd0);
    hart(1'b1, 32'h104, 32'h0); check("running_104_ignored", 32'(halted), 32'd0);

    haltreq = 1'b1;
    step(); check("haltreq_o_set", 32'(haltreq_o), 32'd1);
    hart(1'b1, 32'h100, 32'h0);
    check("halted_after_100", 32'(halted), 32'd1);
    check("ready_halted", 32'(cmd_ready), 32'd1);
    step(); check("haltreq_o_drop", 32'(haltreq_o), 32'd0);
    haltreq = 1'b0;

    dbg_wr(5'h00, 32'hDEAD_BEEF);
    dbg_wr(5'h01, 32'h1111_1111);
    dbg_wr(5'h10, 32'h5);
    check("dbg_data0", data0, 32'h5);

    cmd_valid = 1'b1; cmd_data = 32'h0022_1000;
    step(); cmd_valid = 1'b0;
    check("busy_go", 32'(busy), 32'd1);
    check("ready_go", 32'(cmd_ready), 32'd0);

    for (int i = 0; i < 12; i++) begin
      hart(tbl[i].we, tbl[i].addr, tbl[i].wdata);
      check($sformatf("tbl[%0d]", i), rdata, tbl[i].exp);
    end

    dbg_wr(5'h10, 32'h99); check("dbg_data0_drop_go", data0, 32'h5);
    hart(1'b1, 32'h200, 32'h77); check("hart_data0", data0, 32'h77);
    hart(1'b1, 32'h104, 32'h0);
    check("done_pulse", 32'(done), 32'd1);
    check("busy_clear", 32'(busy), 32'd0);
    check("err_ok", 32'(err), 32'd0);
    step(); check("done_once", 32'(done), 32'd0);

    req = 1'b1; we = 1'b1; addr = 32'h200; wdata = 32'hAA;
    pb_we = 1'b1; pb_addr = 5'h10; pb_wdata = 32'hBB;
    step(); req = 1'b0; we = 1'b0; pb_we = 1'b0;
    check("data0_hart_wins", data0, 32'hAA);

    cmd_valid = 1'b1; cmd_data = 32'h1234_5678;
    step(); cmd_valid = 1'b0;
    hart(1'b1, 32'h10C, 32'h0);
    check("exc_done", 32'(done), 32'd1);
    check("exc_err", 32'(err), 32'd1);
    step(); step();
    check("err_sticky", 32'(err), 32'd1);
    hart(1'b0, 32'h400, 32'h0); check("cmdw2", rdata, 32'h1234_5678);

    cmd_valid = 1'b1; cmd_data = 32'h0000_ABCD; resumereq = 1'b1;
    step(); cmd_valid = 1'b0;
    check("cmd_over_resume", 32'(busy), 32'd1);
    check("err_cleared", 32'(err), 32'd0);
    hart(1'b0, 32'h300, 32'h0); check("flags_go", rdata, 32'd1);
    hart(1'b1, 32'h104, 32'h0);
    step();
    hart(1'b0, 32'h300, 32'h0); check("flags_resume", rdata, 32'd2);
    resumereq = 1'b0;
    hart(1'b1, 32'h108, 32'h0); check("resumed", 32'(halted), 32'd0);

    hart(1'b1, 32'h100, 32'h0);
    cmd_valid = 1'b1; cmd_data = 32'h00C0_FFEE;
    step(); cmd_valid = 1'b0;
    dbg_wr(5'h00, 32'hCAFE_F00D);
    hart(1'b0, 32'h0, 32'h0); check("pb_drop_go", rdata, 32'hDEAD_BEEF);
    rst = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h104;
    step(); rst = 1'b0; req = 1'b0; we = 1'b0;
    check("rst_go_no_done", 32'(done), 32'd0);
    check("rst_go_halted", 32'(halted), 32'd0);
    check("rst_go_data0", data0, 32'd0);
    step(); check("rst_go_no_done2", 32'(done), 32'd0);
    hart(1'b0, 32'h300, 32'h0); check("rst_go_flags", rdata, 32'd0);
    hart(1'b0, 32'h400, 32'h0); check("rst_go_cmdw", rdata, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
